sc_io_display: RTL and testbench
================================

SC_IO_DISPLAY -- requirements
Module: sc_io_display

Interface
REQ-001 SHALL have parameter LZ_BLANK, default 0; when 1, a leading tens digit of 0 is blanked.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port out_port0, input, 32, CPU output port 0 value, shown on hex1:hex0.
REQ-005 SHALL have port out_port1, input, 32, CPU output port 1 value, shown on hex3:hex2.
REQ-006 SHALL have port out_port2, input, 32, CPU output port 2 value, shown on hex5:hex4.
REQ-007 SHALL have ports hex0..hex5, output, 7 each, active-low segments, bit[6]=g .. bit[0]=a, registered.
REQ-008 SHALL have port busy, output, 1, high while a conversion is in SHIFT.
REQ-009 SHALL have port update, output, 1, one-cycle pulse when a digit pair is written.

Function
REQ-010 SHALL run a free-running FSM LOAD -> SHIFT -> STORE -> LOAD; no idle state.
REQ-011 SHALL service ports round-robin 0,1,2,0,...; port index advances in STORE and wraps 2 -> 0.
REQ-012 In LOAD, SHALL sample the selected port (32 bits) into a holding register; only this sample is converted.
REQ-013 SHALL convert bits [6:0] to two BCD digits by double-dabble: 7 SHIFT cycles, add-3 on any digit >= 5 before each shift; 15-bit working register.
REQ-014 SHALL stay in SHIFT exactly 7 cycles, counted by a 3-bit counter cleared in LOAD.
REQ-015 Out-of-range rule: if sampled bits [31:7] are nonzero or [6:0] > 99, SHALL write dash 7'b0111111 to both digits of that pair.
REQ-016 In STORE, SHALL write only the selected pair; the other four hex outputs hold.
REQ-017 Latency: LOAD->STORE is 9 cycles per port; full refresh period is 27 cycles; a new value appears on hex at most 36 cycles after it is stable.
REQ-018 Input changes during SHIFT/STORE SHALL NOT affect the conversion in flight.
REQ-019 SHALL assert update on the cycle after the STORE edge, coincident with the new hex value; never two consecutive cycles.
REQ-020 Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-021 With LZ_BLANK=1 and tens digit 0, SHALL drive the tens display blank; units digit 0 is always shown.

Reset
REQ-022 While resetn=0 at a clock edge, SHALL set hex0..hex5=7'b1111111, busy=0, update=0, state=LOAD, port index=0, counter=0.
REQ-023 Reset mid-SHIFT or in STORE SHALL discard the partial result; no hex output changes except to blank.
REQ-024 First LOAD SHALL occur on the first edge with resetn=1; port 0 is serviced first.

Structure
REQ-025 Shared package sc_io_pkg SHALL hold FSM state encodings, SEG_BLANK, SEG_DASH, the digit code table, and NUM_PORTS=3.
REQ-026 SHALL instantiate one combinational sub-module sc_seg7_decode (4-bit digit -> 7-bit active-low pattern), used twice.
REQ-027 SHALL be placed downstream of the CPU top, consuming its out_port0..2 directly, with no handshake back.

Verification
REQ-028 Reset then idle: resetn low 3 cycles -> all hex=1111111, busy=0, update=0; after release, hex1:hex0 valid at cycle 10.
REQ-029 out_port0=42, port1=7, port2=99 -> hex1=0011001, hex0=0100100; hex3=1000000, hex2=1111000; hex5=hex4=0010000; 3 update pulses 9 cycles apart.
REQ-030 Out-of-range: port1=100, then 32'h0000_0080 -> hex3=hex2=0111111 both times; other pairs unchanged.
REQ-031 LZ_BLANK=1, port2=5 -> hex5=1111111, hex4=0010010; port2=0 -> hex5 blank, hex4=1000000.
REQ-032 Change port0 from 12 to 34 on cycle 3 of its SHIFT -> 12 displayed now, 34 after the next port-0 pass (27 cycles later).
REQ-033 Assert resetn low during port-1 SHIFT -> all hex blank next cycle; after release, conversion restarts at port 0, with busy and update timing per REQ-014/019.

Source files
------------

// File: rtl/sc_io_display_pkg.sv
// ---------------------------------------------------------------------------
// sc_io_pkg
// Shared definitions for the CPU output-port seven-segment display block:
//   - FSM state encoding for the LOAD/SHIFT/STORE conversion loop
//   - segment constants (blank, dash) and the 0..9 digit code table
//   - port count and conversion limits
//   - one double-dabble step helper used by the converter
// Segment patterns are active-low, bit[6]=g .. bit[0]=a.
// ---------------------------------------------------------------------------
package sc_io_pkg;

  // Conversion loop states; there is deliberately no idle state.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  localparam int NUM_PORTS    = 3;
  localparam int SHIFT_CYCLES = 7;

  // Largest value that fits in two decimal digits.
  localparam logic [6:0] MAX_VALUE = 7'd99;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Digit code table, index 9 on the left down to index 0 on the right.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Add-3 correction applied to a BCD digit before it is doubled.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // One double-dabble step on the 15-bit working register:
  // [14:11] tens, [10:7] units, [6:0] remaining binary bits.
  function automatic logic [14:0] dabble_step(input logic [14:0] w);
    logic [14:0] adj;
    adj = {add3(w[14:11]), add3(w[10:7]), w[6:0]};
    return {adj[13:0], 1'b0};
  endfunction

endpackage

// File: rtl/sc_io_display_decode.sv
// ---------------------------------------------------------------------------
// sc_seg7_decode
// Purely combinational BCD digit to seven-segment pattern decoder.
// Ports:
//   digit - 4-bit BCD digit (values above 9 show blank)
//   seg   - 7-bit active-low segment pattern, bit[6]=g .. bit[0]=a
// ---------------------------------------------------------------------------
module sc_seg7_decode
  import sc_io_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup; anything that is not a decimal digit is shown as blank.
  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/sc_io_display.sv
// ---------------------------------------------------------------------------
// sc_io_display
// Shows the low 7 bits of three CPU output ports as two decimal digits each
// on six seven-segment displays. A free-running loop samples one port,
// converts it to BCD by double-dabble over 7 cycles and writes that port's
// digit pair, then moves on to the next port round-robin.
// Parameters:
//   LZ_BLANK  - when 1, a tens digit of 0 is shown blank
// Ports:
//   clock     - single clock, rising edge
//   resetn    - synchronous active-low reset
//   out_port0 - CPU port 0, shown on hex1 (tens) : hex0 (units)
//   out_port1 - CPU port 1, shown on hex3 (tens) : hex2 (units)
//   out_port2 - CPU port 2, shown on hex5 (tens) : hex4 (units)
//   hex0..5   - registered active-low segment patterns
//   busy      - high while a conversion is shifting
//   update    - one-cycle pulse when a digit pair has just been written
// ---------------------------------------------------------------------------
module sc_io_display
  import sc_io_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        update
);

  state_t      state;
  state_t      state_next;
  logic [1:0]  port_idx;
  logic [2:0]  shift_cnt;
  logic [31:0] hold_value;
  logic [14:0] working;
  logic [31:0] port_value;
  logic        load_en;
  logic        shift_en;
  logic        store_en;
  logic        out_of_range;
  logic [6:0]  tens_seg;
  logic [6:0]  units_seg;
  logic [6:0]  tens_code;
  logic [6:0]  units_code;

  // State register. Reset parks the loop in LOAD so the first edge after
  // release samples port 0.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one LOAD cycle, seven SHIFT cycles, one STORE cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (shift_cnt == 3'(SHIFT_CYCLES - 1)) begin
          state_next = ST_STORE;
        end
      end
      ST_STORE: state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  // Output decode of the state into datapath strobes and the busy flag.
  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    store_en = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_LOAD:  load_en = 1'b1;
      ST_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      ST_STORE: store_en = 1'b1;
      default:  load_en = 1'b0;
    endcase
  end

  // Round-robin port selection.
  always_comb begin
    case (port_idx)
      2'd0:    port_value = out_port0;
      2'd1:    port_value = out_port1;
      2'd2:    port_value = out_port2;
      default: port_value = out_port0;
    endcase
  end

  // Conversion datapath. The sample taken in LOAD is the only thing that is
  // converted, so port changes during SHIFT/STORE cannot disturb it.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hold_value <= '0;
      working    <= '0;
      shift_cnt  <= '0;
    end else if (load_en) begin
      hold_value <= port_value;
      working    <= {8'd0, port_value[6:0]};
      shift_cnt  <= '0;
    end else if (shift_en) begin
      working    <= dabble_step(working);
      shift_cnt  <= shift_cnt + 3'd1;
    end
  end

  // Anything with upper bits set or above 99 cannot be shown in two digits.
  assign out_of_range = (hold_value[31:7] != '0) || (hold_value[6:0] > MAX_VALUE);

  sc_seg7_decode u_tens_decode (
    .digit (working[14:11]),
    .seg   (tens_seg)
  );

  sc_seg7_decode u_units_decode (
    .digit (working[10:7]),
    .seg   (units_seg)
  );

  // Final patterns for the pair: dashes when out of range, optional blanking
  // of a zero tens digit. The units digit is always shown.
  always_comb begin
    tens_code  = tens_seg;
    units_code = units_seg;
    if (out_of_range) begin
      tens_code  = SEG_DASH;
      units_code = SEG_DASH;
    end else if (LZ_BLANK && (working[14:11] == 4'd0)) begin
      tens_code  = SEG_BLANK;
    end
  end

  // Display registers, port index and the update pulse. Only the pair of the
  // port just converted is written; the other four displays hold.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hex0     <= SEG_BLANK;
      hex1     <= SEG_BLANK;
      hex2     <= SEG_BLANK;
      hex3     <= SEG_BLANK;
      hex4     <= SEG_BLANK;
      hex5     <= SEG_BLANK;
      port_idx <= '0;
      update   <= 1'b0;
    end else begin
      update <= store_en;
      if (store_en) begin
        case (port_idx)
          2'd0: begin
            hex0 <= units_code;
            hex1 <= tens_code;
          end
          2'd1: begin
            hex2 <= units_code;
            hex3 <= tens_code;
          end
          default: begin
            hex4 <= units_code;
            hex5 <= tens_code;
          end
        endcase
        if (port_idx == 2'(NUM_PORTS - 1)) begin
          port_idx <= '0;
        end else begin
          port_idx <= port_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_io_display.sv
// ---------------------------------------------------------------------------
// tb_sc_io_display
// Drives two instances (LZ_BLANK=0 and LZ_BLANK=1) from the same ports.
// A sampler predicts each conversion from the documented schedule (a port is
// sampled every 9 edges after reset release, round-robin, result shown 8 edges
// later) and decimal arithmetic, and queues the expected digit pairs. A
// monitor pops them when the update pulse is due and checks all six displays,
// busy and update every cycle.
// ---------------------------------------------------------------------------
module tb_sc_io_display;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;

  logic [6:0] p_hex0, p_hex1, p_hex2, p_hex3, p_hex4, p_hex5;
  logic [6:0] z_hex0, z_hex1, z_hex2, z_hex3, z_hex4, z_hex5;
  logic       p_busy, p_update, z_busy, z_update;

  always #5 clock = ~clock;

  sc_io_display #(.LZ_BLANK(1'b0)) dut_plain (
    .clock     (clock),
    .resetn    (resetn),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .hex0      (p_hex0),
    .hex1      (p_hex1),
    .hex2      (p_hex2),
    .hex3      (p_hex3),
    .hex4      (p_hex4),
    .hex5      (p_hex5),
    .busy      (p_busy),
    .update    (p_update)
  );

  sc_io_display #(.LZ_BLANK(1'b1)) dut_lz (
    .clock     (clock),
    .resetn    (resetn),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .hex0      (z_hex0),
    .hex1      (z_hex1),
    .hex2      (z_hex2),
    .hex3      (z_hex3),
    .hex4      (z_hex4),
    .hex5      (z_hex5),
    .busy      (z_busy),
    .update    (z_update)
  );

  logic [6:0] act_plain [6];
  logic [6:0] act_lz    [6];
  assign act_plain[0] = p_hex0;
  assign act_plain[1] = p_hex1;
  assign act_plain[2] = p_hex2;
  assign act_plain[3] = p_hex3;
  assign act_plain[4] = p_hex4;
  assign act_plain[5] = p_hex5;
  assign act_lz[0]    = z_hex0;
  assign act_lz[1]    = z_hex1;
  assign act_lz[2]    = z_hex2;
  assign act_lz[3]    = z_hex3;
  assign act_lz[4]    = z_hex4;
  assign act_lz[5]    = z_hex5;

  typedef struct {
    int         due;
    int         port;
    logic [6:0] tens_plain;
    logic [6:0] units_plain;
    logic [6:0] tens_lz;
    logic [6:0] units_lz;
  } sb_entry_t;

  sb_entry_t  sb [$];
  logic [6:0] disp_plain [6];
  logic [6:0] disp_lz    [6];
  int         cyc = 0;
  bit         in_reset = 1'b0;
  bit         started = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {tens, units} for a sampled 32-bit value.
  function automatic logic [13:0] ref_pair(input logic [31:0] v, input bit lz);
    int n;
    logic [6:0] t;
    if (v > 32'd99) return {7'b0111111, 7'b0111111};
    n = int'(v);
    t = (lz && (n / 10) == 0) ? 7'b1111111 : ref_seg(n / 10);
    return {t, ref_seg(n % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] p2, input int cycles);
    out_port0 = p0;
    out_port1 = p1;
    out_port2 = p2;
    repeat (cycles) @(negedge clock);
  endtask

  // Waits (bounded) until the edge count sits at a given point of the
  // 27-cycle refresh period.
  task automatic waitPhase(input int phase);
    int tries = 0;
    while ((cyc % 27) != phase && tries < 100) begin
      @(negedge clock);
      tries++;
    end
    checkOutput("phase_wait", 32'(cyc % 27), 32'(phase));
  endtask

  // Sampler: counts edges since reset release and predicts each conversion.
  initial begin
    forever begin
      @(posedge clock);
      started = 1'b1;
      if (!resetn) begin
        cyc      = 0;
        in_reset = 1'b1;
      end else begin
        sb_entry_t e;
        logic [31:0] v;
        logic [13:0] pp, pz;
        in_reset = 1'b0;
        cyc++;
        if ((cyc - 1) % 9 == 0) begin
          e.port = ((cyc - 1) / 9) % 3;
          v = (e.port == 0) ? out_port0 : (e.port == 1) ? out_port1 : out_port2;
          pp = ref_pair(v, 1'b0);
          pz = ref_pair(v, 1'b1);
          e.due         = cyc + 8;
          e.tens_plain  = pp[13:7];
          e.units_plain = pp[6:0];
          e.tens_lz     = pz[13:7];
          e.units_lz    = pz[6:0];
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: checks pulses, busy and every display each cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        bit exp_upd;
        bit exp_busy;
        if (in_reset) begin
          sb.delete();
          for (int i = 0; i < 6; i++) begin
            disp_plain[i] = 7'b1111111;
            disp_lz[i]    = 7'b1111111;
          end
        end
        exp_upd  = (sb.size() > 0) && (sb[0].due == cyc);
        exp_busy = (cyc > 0) && (((cyc - 1) % 9) < 7);
        checkOutput("update_plain", 32'(p_update), 32'(exp_upd));
        checkOutput("update_lz", 32'(z_update), 32'(exp_upd));
        checkOutput("busy_plain", 32'(p_busy), 32'(exp_busy));
        checkOutput("busy_lz", 32'(z_busy), 32'(exp_busy));
        if ((p_update || exp_upd) && sb.size() > 0) begin
          sb_entry_t e;
          e = sb.pop_front();
          disp_plain[2*e.port]   = e.units_plain;
          disp_plain[2*e.port+1] = e.tens_plain;
          disp_lz[2*e.port]      = e.units_lz;
          disp_lz[2*e.port+1]    = e.tens_lz;
        end
        for (int i = 0; i < 6; i++) begin
          checkOutput($sformatf("plain_hex%0d", i), 32'(act_plain[i]), 32'(disp_plain[i]));
          checkOutput($sformatf("lz_hex%0d", i), 32'(act_lz[i]), 32'(disp_lz[i]));
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized phase.
  initial begin
    resetn    = 1'b0;
    out_port0 = '0;
    out_port1 = '0;
    out_port2 = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    $display("[TB] reset released");
    applyStimulus(32'd0, 32'd0, 32'd0, 12);
    applyStimulus(32'd42, 32'd7, 32'd99, 30);
    applyStimulus(32'd42, 32'd100, 32'd99, 30);
    applyStimulus(32'd42, 32'h0000_0080, 32'd99, 30);
    applyStimulus(32'd42, 32'd7, 32'd5, 30);
    applyStimulus(32'd42, 32'd7, 32'd0, 30);
    applyStimulus(32'd12, 32'd7, 32'd0, 30);
    waitPhase(3);
    out_port0 = 32'd34;
    repeat (60) @(negedge clock);
    waitPhase(13);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (30) @(negedge clock);
    for (int it = 0; it < 60; it++) begin
      logic [31:0] r0, r1, r2;
      r0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
      r1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
      r2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
      applyStimulus(r0, r1, r2, $urandom_range(1, 30));
      if ($urandom_range(0, 19) == 0) begin
        resetn = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        resetn = 1'b1;
      end
    end
    repeat (20) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
